// File: rtl/tx_eq_pkg.sv
// Shared types and helpers for the TX FFE de-emphasis tap search.
//   eq_state_t    : sequencer state encoding
//   TAP_W_DEFAULT : default tap code width
//   tap_sweep_len : number of codes visited by one sweep
package tx_eq_pkg;

  localparam int unsigned TAP_W_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_DISCARD = 3'd2,
    ST_MEASURE = 3'd3,
    ST_COMPARE = 3'd4,
    ST_FINAL   = 3'd5,
    ST_DONE    = 3'd6
  } eq_state_t;

  function automatic int unsigned tap_sweep_len(input int unsigned tap_min,
                                                input int unsigned tap_max,
                                                input int unsigned tap_step);
    return ((tap_max - tap_min) / tap_step) + 32'd1;
  endfunction

endpackage

// File: rtl/eq_wait_timer.sv
// Loadable down-counter shared by the settle wait and the eye-result timeout.
//   clock, reset      : clock, async active-high reset
//   i_load            : load i_load_val this cycle
//   i_load_val        : cycles to wait minus one
//   o_expired_c       : counter at zero (combinational)
module eq_wait_timer #(
  parameter int unsigned CNT_W = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_expired_c
);

  logic [CNT_W-1:0] r_cnt;

  // Count down to zero and park there until reloaded.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expired_c = (r_cnt == '0);

endmodule

// File: rtl/tx_eq_tap_search.sv
// Sweeps the TX FFE de-emphasis tap code, measures the eye opening for each
// code and applies the code with the largest opening (lowest code on ties).
// A missing eye result aborts the sweep and restores the safe default code.
//   clock, reset   : sampling clock, async active-high reset
//   start          : begin a sweep (accepted only in IDLE/DONE)
//   opening        : eye opening from eye_calculation
//   opening_ready  : one-cycle pulse, opening valid
//   tap_code       : code applied to the TX equalizer
//   busy           : sweep in progress
//   done           : sweep finished, held until the next accepted start
//   timeout_err    : last sweep aborted on a measurement timeout
//   best_code      : winning code
//   best_opening   : opening measured at best_code
module tx_eq_tap_search
  import tx_eq_pkg::*;
#(
  parameter int unsigned TAP_W          = TAP_W_DEFAULT,
  parameter int unsigned TAP_MIN        = 0,
  parameter int unsigned TAP_MAX        = 15,
  parameter int unsigned TAP_STEP       = 1,
  parameter int unsigned TAP_DEFAULT    = 0,
  parameter int unsigned SETTLE_CYCLES  = 64,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  real              opening,
  input  logic             opening_ready,
  output logic [TAP_W-1:0] tap_code,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [TAP_W-1:0] best_code,
  output real              best_opening
);

  localparam int unsigned WAIT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ?
                                     SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W    = $clog2(WAIT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TAP_W-1:0] TAP_FIRST    = TAP_W'(TAP_MIN);
  localparam logic [TAP_W-1:0] TAP_SAFE     = TAP_W'(TAP_DEFAULT);
  localparam logic [TAP_W:0]   TAP_LAST     = (TAP_W+1)'(TAP_MAX);
  localparam logic [TAP_W:0]   TAP_INC      = (TAP_W+1)'(TAP_STEP);

  eq_state_t        r_state;
  logic [TAP_W-1:0] r_tap;
  logic [TAP_W-1:0] r_best_code;
  logic             r_busy;
  logic             r_done;
  logic             r_terr;
  logic             r_first;
  real              r_best_op;
  real              r_meas;

  eq_state_t        w_state_nxt;
  logic [TAP_W-1:0] w_tap_nxt;
  logic [TAP_W-1:0] w_best_code_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_terr_nxt;
  logic             w_first_nxt;
  real              w_best_op_nxt;
  real              w_meas_nxt;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_expired_c;
  logic [TAP_W:0]   w_tap_sum;

  // One extra bit so the last-code test cannot wrap.
  assign w_tap_sum = {1'b0, r_tap} + TAP_INC;

  eq_wait_timer #(
    .CNT_W (CNT_W)
  ) u_wait_timer (
    .clock       (clock),
    .reset       (reset),
    .i_load      (w_load),
    .i_load_val  (w_load_val),
    .o_expired_c (w_expired_c)
  );

  // State and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_tap       <= TAP_SAFE;
      r_best_code <= TAP_SAFE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_terr      <= 1'b0;
      r_first     <= 1'b0;
      r_best_op   <= 0.0;
      r_meas      <= 0.0;
    end else begin
      r_state     <= w_state_nxt;
      r_tap       <= w_tap_nxt;
      r_best_code <= w_best_code_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_terr      <= w_terr_nxt;
      r_first     <= w_first_nxt;
      r_best_op   <= w_best_op_nxt;
      r_meas      <= w_meas_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_tap_nxt       = r_tap;
    w_best_code_nxt = r_best_code;
    w_busy_nxt      = r_busy;
    w_done_nxt      = r_done;
    w_terr_nxt      = r_terr;
    w_first_nxt     = r_first;
    w_best_op_nxt   = r_best_op;
    w_meas_nxt      = r_meas;
    w_load          = 1'b0;
    w_load_val      = SETTLE_LOAD;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_SETTLE;
          w_tap_nxt   = TAP_FIRST;
          w_busy_nxt  = 1'b1;
          w_done_nxt  = 1'b0;
          w_terr_nxt  = 1'b0;
          w_first_nxt = 1'b1;
          w_load      = 1'b1;
          w_load_val  = SETTLE_LOAD;
        end
      end

      ST_SETTLE: begin
        if (w_expired_c) begin
          w_state_nxt = ST_DISCARD;
          w_load      = 1'b1;
          w_load_val  = TIMEOUT_LOAD;
        end
      end

      // The first window after a code change straddles it; drop its value.
      ST_DISCARD, ST_MEASURE: begin
        if (opening_ready) begin
          w_load     = 1'b1;
          w_load_val = TIMEOUT_LOAD;
          if (r_state == ST_MEASURE) begin
            w_meas_nxt  = opening;
            w_state_nxt = ST_COMPARE;
          end else begin
            w_state_nxt = ST_MEASURE;
          end
        end else if (w_expired_c) begin
          w_state_nxt     = ST_DONE;
          w_tap_nxt       = TAP_SAFE;
          w_best_code_nxt = TAP_SAFE;
          w_terr_nxt      = 1'b1;
          w_busy_nxt      = 1'b0;
          w_done_nxt      = 1'b1;
        end
      end

      // Strict compare keeps the lower code on ties; first_flag admits
      // negative openings on the first code.
      ST_COMPARE: begin
        if (r_first || (r_meas > r_best_op)) begin
          w_best_op_nxt   = r_meas;
          w_best_code_nxt = r_tap;
        end
        w_first_nxt = 1'b0;
        if (w_tap_sum > TAP_LAST) begin
          w_state_nxt = ST_FINAL;
        end else begin
          w_tap_nxt   = w_tap_sum[TAP_W-1:0];
          w_state_nxt = ST_SETTLE;
          w_load      = 1'b1;
          w_load_val  = SETTLE_LOAD;
        end
      end

      ST_FINAL: begin
        w_tap_nxt   = r_best_code;
        w_state_nxt = ST_DONE;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign tap_code     = r_tap;
  assign busy         = r_busy;
  assign done         = r_done;
  assign timeout_err  = r_terr;
  assign best_code    = r_best_code;
  assign best_opening = r_best_op;

endmodule

// File: tb/tb_tx_eq_tap_search.sv
// Bench for tx_eq_tap_search: three DUT configurations share one clock, each
// fed by a stub eye source that restarts its window timing on every code change
// and reports a garbage 9.9 on the first window after a change.
module tb_tx_eq_tap_search;
  import tx_eq_pkg::*;

  localparam int SET = 8;
  localparam int TMO = 64;
  localparam int P   = 11;
  localparam int NI  = 3;
  localparam int NROW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       start_v [NI];
  real        op_v    [NI];
  logic       rdy_v   [NI];
  logic [3:0] tap_o   [NI];
  logic [3:0] bc_o    [NI];
  logic       busy_o  [NI];
  logic       done_o  [NI];
  logic       terr_o  [NI];
  real        bo_o    [NI];

  logic [1:0] tap_a, bc_a, tap_b, bc_b;
  logic [3:0] tap_c, bc_c;

  tx_eq_tap_search #(.TAP_W(2), .TAP_MIN(0), .TAP_MAX(3), .TAP_STEP(1), .TAP_DEFAULT(0),
                     .SETTLE_CYCLES(SET), .TIMEOUT_CYCLES(TMO)) u_dut_a (
    .clock(clk), .reset(rst), .start(start_v[0]), .opening(op_v[0]), .opening_ready(rdy_v[0]),
    .tap_code(tap_a), .busy(busy_o[0]), .done(done_o[0]), .timeout_err(terr_o[0]),
    .best_code(bc_a), .best_opening(bo_o[0]));

  tx_eq_tap_search #(.TAP_W(2), .TAP_MIN(0), .TAP_MAX(2), .TAP_STEP(1), .TAP_DEFAULT(0),
                     .SETTLE_CYCLES(SET), .TIMEOUT_CYCLES(TMO)) u_dut_b (
    .clock(clk), .reset(rst), .start(start_v[1]), .opening(op_v[1]), .opening_ready(rdy_v[1]),
    .tap_code(tap_b), .busy(busy_o[1]), .done(done_o[1]), .timeout_err(terr_o[1]),
    .best_code(bc_b), .best_opening(bo_o[1]));

  tx_eq_tap_search #(.TAP_W(4), .TAP_MIN(5), .TAP_MAX(5), .TAP_STEP(1), .TAP_DEFAULT(0),
                     .SETTLE_CYCLES(SET), .TIMEOUT_CYCLES(TMO)) u_dut_c (
    .clock(clk), .reset(rst), .start(start_v[2]), .opening(op_v[2]), .opening_ready(rdy_v[2]),
    .tap_code(tap_c), .busy(busy_o[2]), .done(done_o[2]), .timeout_err(terr_o[2]),
    .best_code(bc_c), .best_opening(bo_o[2]));

  assign tap_o[0] = 4'(tap_a);
  assign bc_o[0]  = 4'(bc_a);
  assign tap_o[1] = 4'(tap_b);
  assign bc_o[1]  = 4'(bc_b);
  assign tap_o[2] = tap_c;
  assign bc_o[2]  = bc_c;

  function automatic int imin(input int g);
    return (g == 2) ? 5 : 0;
  endfunction

  function automatic int imax(input int g);
    return (g == 0) ? 3 : ((g == 1) ? 2 : 5);
  endfunction

  // Stub eye source state
  real        vals     [NI][16];
  logic       mute     [NI];
  int         scnt     [NI];
  logic [3:0] sprev    [NI];
  logic       sbusy    [NI];
  int         garb_cyc [NI];
  int         garb_tap [NI];
  int         cap_cyc  [NI];
  int         log_g = 0;
  int         order_q[$];

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      rdy_v[g] = 1'b0;
      if (rst) begin
        scnt[g]  = 0;
        sprev[g] = tap_o[g];
        sbusy[g] = 1'b0;
      end else begin
        if (busy_o[g] && (!sbusy[g] || (tap_o[g] != sprev[g]))) begin
          scnt[g] = 0;
          if (g == log_g) order_q.push_back(int'(tap_o[g]));
        end else begin
          scnt[g] = scnt[g] + 1;
        end
        sprev[g] = tap_o[g];
        sbusy[g] = busy_o[g];
        if ((scnt[g] % P) == (P - 1)) begin
          if (scnt[g] == P - 1) begin
            op_v[g]     = 9.9;
            rdy_v[g]    = 1'b1;
            garb_cyc[g] = cyc + 1;
            garb_tap[g] = int'(tap_o[g]);
          end else if (!(mute[g] && (tap_o[g] == 4'd2))) begin
            op_v[g]  = vals[g][tap_o[g]];
            rdy_v[g] = 1'b1;
            if (scnt[g] == 2 * P - 1) cap_cyc[g] = cyc + 1;
          end
        end
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_real(input string nm, input real act, input real exp);
    real d;
    d = act - exp;
    if (d < 0.0) d = -d;
    checks++;
    if (d > 1e-9) begin
      failures++;
      $display("FAIL %s: got %f expected %f", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    int  g;
    real v[4];
    int  exp_code;
    real exp_op;
  } vec_t;

  vec_t tbl[NROW];

  task automatic set_row(input int i, input int g, input real a, input real b,
                         input real c, input real d, input int ec, input real eo);
    tbl[i].g = g;
    tbl[i].v[0] = a; tbl[i].v[1] = b; tbl[i].v[2] = c; tbl[i].v[3] = d;
    tbl[i].exp_code = ec;
    tbl[i].exp_op = eo;
  endtask

  task automatic load_row(input int i);
    for (int k = 0; k < 4; k++) vals[tbl[i].g][imin(tbl[i].g) + k] = tbl[i].v[k];
  endtask

  // Reference: largest opening over the swept codes, lowest code on ties.
  task automatic ref_best(input int g, output int code, output real op);
    real mx;
    mx = vals[g][imin(g)];
    for (int c = imin(g); c <= imax(g); c++) if (vals[g][c] > mx) mx = vals[g][c];
    code = -1;
    for (int c = imax(g); c >= imin(g); c--) if (vals[g][c] == mx) code = c;
    op = mx;
  endtask

  // Start a sweep on instance g and wait for done; returns the start edge and done edge.
  task automatic run_sweep(input int g, input bit hold, output int e_cyc, output int d_cyc);
    log_g = g;
    order_q.delete();
    start_v[g] = 1'b1;
    e_cyc = cyc + 1;
    tick();
    if (!hold) start_v[g] = 1'b0;
    for (int k = 0; k < 3000 && !done_o[g]; k++) tick();
    start_v[g] = 1'b0;
    d_cyc = cyc;
    check_int($sformatf("done_wait_g%0d", g), int'(done_o[g]), 1);
  endtask

  task automatic check_result(input int g, input string tag, input int ec, input real eo);
    check_int({tag, "_best_code"}, int'(bc_o[g]), ec);
    check_real({tag, "_best_opening"}, bo_o[g], eo);
    check_int({tag, "_tap_code"}, int'(tap_o[g]), ec);
    check_int({tag, "_done"}, int'(done_o[g]), 1);
    check_int({tag, "_busy"}, int'(busy_o[g]), 0);
    check_int({tag, "_timeout_err"}, int'(terr_o[g]), 0);
    check_int({tag, "_no_garbage"}, int'(bo_o[g] > 5.0), 0);
    check_int({tag, "_order_len"}, order_q.size(),
              int'(tap_sweep_len(imin(g), imax(g), 1)));
    for (int k = 0; k < order_q.size(); k++)
      check_int($sformatf("%s_order%0d", tag, k), order_q[k], imin(g) + k);
  endtask

  task automatic check_reset(input int g, input string tag);
    check_int({tag, "_tap_code"}, int'(tap_o[g]), 0);
    check_int({tag, "_busy"}, int'(busy_o[g]), 0);
    check_int({tag, "_done"}, int'(done_o[g]), 0);
    check_int({tag, "_timeout_err"}, int'(terr_o[g]), 0);
    check_int({tag, "_best_code"}, int'(bc_o[g]), 0);
    check_real({tag, "_best_opening"}, bo_o[g], 0.0);
  endtask

  initial begin
    int e, d, ec, gg;
    real eo;

    set_row(0, 0,  0.40,  0.55,  0.55,  0.30, 1,  0.55);
    set_row(1, 0,  0.10,  0.20,  0.30,  0.40, 3,  0.40);
    set_row(2, 0,  0.90,  0.10,  0.10,  0.10, 0,  0.90);
    set_row(3, 0, -0.50, -0.50, -0.50, -0.50, 0, -0.50);
    set_row(4, 1, -0.20, -0.05, -0.10,  0.00, 1, -0.05);
    set_row(5, 2,  0.33,  0.00,  0.00,  0.00, 5,  0.33);

    for (int g = 0; g < NI; g++) begin
      start_v[g] = 1'b0;
      mute[g] = 1'b0;
      for (int c = 0; c < 16; c++) vals[g][c] = 0.0;
    end

    repeat (3) tick();
    for (int g = 0; g < NI; g++) check_reset(g, $sformatf("reset_g%0d", g));
    rst = 1'b0;
    tick();

    // Table-driven sweeps
    for (int i = 0; i < NROW; i++) begin
      load_row(i);
      run_sweep(tbl[i].g, 1'b0, e, d);
      check_result(tbl[i].g, $sformatf("row%0d", i), tbl[i].exp_code, tbl[i].exp_op);
      if (tbl[i].g == 2) begin
        check_int("single_done_after_capture", d, cap_cyc[2] + 2);
        check_int("single_total_latency", d - e, 2 * P + 2);
      end
    end

    // Randomized sweeps against the reference model
    for (int r = 0; r < 8; r++) begin
      gg = r % 2;
      for (int c = imin(gg); c <= imax(gg); c++)
        vals[gg][c] = real'(int'($urandom_range(0, 4)) - 2) * 0.25;
      ref_best(gg, ec, eo);
      run_sweep(gg, 1'b0, e, d);
      check_result(gg, $sformatf("rand%0d", r), ec, eo);
    end

    // Eye source goes silent during the code-2 measurement
    load_row(0);
    mute[0] = 1'b1;
    run_sweep(0, 1'b0, e, d);
    check_int("tmo_garbage_code", garb_tap[0], 2);
    check_int("tmo_edge", d, garb_cyc[0] + TMO);
    check_int("tmo_err", int'(terr_o[0]), 1);
    check_int("tmo_busy", int'(busy_o[0]), 0);
    check_int("tmo_tap_code", int'(tap_o[0]), 0);
    check_int("tmo_best_code", int'(bc_o[0]), 0);
    check_real("tmo_best_opening_held", bo_o[0], 0.55);
    mute[0] = 1'b0;

    // Asynchronous reset during the code-2 settle
    log_g = 0;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    for (int k = 0; k < 500 && tap_o[0] != 4'd2; k++) tick();
    check_int("rst_reached_code2", int'(tap_o[0]), 2);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check_reset(0, "midrst");
    tick();
    rst = 1'b0;
    tick();
    run_sweep(0, 1'b0, e, d);
    check_result(0, "after_rst", 1, 0.55);

    // start held high for the whole sweep
    run_sweep(0, 1'b1, e, d);
    check_result(0, "start_held", 1, 0.55);

    // start while done restarts immediately
    load_row(1);
    log_g = 0;
    order_q.delete();
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    check_int("restart_done_drop", int'(done_o[0]), 0);
    check_int("restart_busy", int'(busy_o[0]), 1);
    for (int k = 0; k < 3000 && !done_o[0]; k++) tick();
    check_result(0, "restart", 3, 0.40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
